// File: rtl/mul_div_unit_if.sv
//------------------------------------------------------------------------------
// Module      : mul_div_unit_if
// Description : Start/Busy/Done handshake bundle between the core (master)
//               and the iterative RV32M multiply/divide unit (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif
`ifndef ALU_MUL
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_REM    5'd15
`endif

interface mul_div_unit_if #(
  parameter int DATA_W = 32
);
  logic                    Start;
  logic [`ALUOP_WIDTH-1:0] AluOperation;
  logic [DATA_W-1:0]       OperandA;
  logic [DATA_W-1:0]       OperandB;
  logic                    Kill;
  logic                    Busy;
  logic                    Done;
  logic [DATA_W-1:0]       Result;

  // Core side: issues requests and flushes, watches the stall/complete flags
  modport master (
    output Start, AluOperation, OperandA, OperandB, Kill,
    input  Busy, Done, Result
  );

  // Execution unit side
  modport slave (
    input  Start, AluOperation, OperandA, OperandB, Kill,
    output Busy, Done, Result
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
//------------------------------------------------------------------------------
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, one bit per cycle, with
//               sign fix-up in a separate cycle and a one-cycle Done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif
`ifndef ALU_MUL
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_REM    5'd15
`endif

module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mul_div_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] c_int_min = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  c_iters   = CNT_W'(DATA_W);

  state_t                  r_state;
  logic [`ALUOP_WIDTH-1:0] r_op;
  logic [DATA_W-1:0]       r_hi;      // product high half / partial remainder
  logic [DATA_W-1:0]       r_lo;      // multiplier -> product low / dividend -> quotient
  logic [DATA_W-1:0]       r_opb;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_neg;     // product / quotient must be negated
  logic                    r_sa;      // dividend sign, gives remainder sign
  logic [DATA_W-1:0]       r_result;

  // Decode of the incoming request
  logic w_is_mul, w_is_div, w_sa, w_sb, w_div0, w_ovf, w_accept;
  logic [DATA_W-1:0] w_mag_a, w_mag_b, w_special;

  assign w_is_mul = (bus.AluOperation == `ALU_MUL)    || (bus.AluOperation == `ALU_MULH) ||
                    (bus.AluOperation == `ALU_MULHSU) || (bus.AluOperation == `ALU_MULHU);
  assign w_is_div = (bus.AluOperation == `ALU_DIV)    || (bus.AluOperation == `ALU_REM);
  // A is signed for everything except MULHU; B only for MUL/MULH/DIV/REM
  assign w_sa     = bus.OperandA[DATA_W-1] && (bus.AluOperation != `ALU_MULHU);
  assign w_sb     = bus.OperandB[DATA_W-1] &&
                    ((bus.AluOperation == `ALU_MUL) || (bus.AluOperation == `ALU_MULH) || w_is_div);
  assign w_mag_a  = w_sa ? -bus.OperandA : bus.OperandA;
  assign w_mag_b  = w_sb ? -bus.OperandB : bus.OperandB;
  assign w_div0   = w_is_div && (bus.OperandB == '0);
  assign w_ovf    = w_is_div && (bus.OperandA == c_int_min) && (bus.OperandB == '1);
  assign w_accept = bus.Start && !bus.Kill && (w_is_mul || w_is_div) &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  // Architecturally defined results for divide-by-zero and signed overflow
  assign w_special = (bus.AluOperation == `ALU_DIV) ? (w_div0 ? '1 : c_int_min)
                                                    : (w_div0 ? bus.OperandA : '0);

  // One iteration of each datapath
  logic [DATA_W:0]       w_msum, w_dshift, w_dsub;
  logic                  w_dge;
  logic [2*DATA_W-1:0]   w_prod, w_prod_fix;
  logic [DATA_W-1:0]     w_quo, w_rem, w_fix_result;
  logic                  w_run_div;

  assign w_run_div  = (r_op == `ALU_DIV) || (r_op == `ALU_REM);
  assign w_msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_dshift   = {r_hi, r_lo[DATA_W-1]};
  assign w_dsub     = w_dshift - {1'b0, r_opb};
  assign w_dge      = ~w_dsub[DATA_W];
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_quo      = r_neg ? -r_lo : r_lo;
  assign w_rem      = r_sa  ? -r_hi : r_hi;

  // Result selection applied in the FIX cycle
  always_comb begin
    w_fix_result = w_rem;
    case (r_op)
      `ALU_MUL:                           w_fix_result = w_prod_fix[DATA_W-1:0];
      `ALU_MULH, `ALU_MULHSU, `ALU_MULHU: w_fix_result = w_prod_fix[2*DATA_W-1:DATA_W];
      `ALU_DIV:                           w_fix_result = w_quo;
      default:                            w_fix_result = w_rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_sa     <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_state  <= S_DONE;
            end else begin
              r_op    <= bus.AluOperation;
              r_neg   <= w_sa ^ w_sb;
              r_sa    <= w_sa;
              r_cnt   <= c_iters;
              r_hi    <= '0;
              r_opb   <= w_is_div ? w_mag_b : w_mag_a;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.Kill) begin
            r_state <= S_IDLE;
          end else begin
            if (w_run_div) begin
              r_hi <= w_dge ? w_dsub[DATA_W-1:0] : w_dshift[DATA_W-1:0];
              r_lo <= {r_lo[DATA_W-2:0], w_dge};
            end else begin
              r_hi <= w_msum[DATA_W:1];
              r_lo <= {w_msum[0], r_lo[DATA_W-1:1]};
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.Kill) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_result;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.Done   = (r_state == S_DONE);
  assign bus.Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: directed corner cases
//               and random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ALU_MUL
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_REM    5'd15
`endif

module tb_mul_div_unit;
  localparam int DATA_W = 32;

  logic        clk;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  mul_div_unit_if #(.DATA_W(DATA_W)) bus();

  mul_div_unit #(.DATA_W(DATA_W), .CNT_W(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb, ub, p;
    bit [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      `ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      `ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      `ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      `ALU_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      `ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
    endcase
  endfunction

  // Issue one op at the current negedge (cycle 0) and check its completion.
  // With hold=1 the task returns on the Done cycle so a follow-up op can start there.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit hold);
    int          done_cyc, busy_cnt;
    logic [31:0] exp, res;
    bit          special;
    exp     = model(op, a, b);
    special = (op == `ALU_DIV || op == `ALU_REM) &&
              (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    bus.Start = 1'b1; bus.AluOperation = op; bus.OperandA = a; bus.OperandB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.OperandA = $urandom; bus.OperandB = $urandom;
    done_cyc = 0; busy_cnt = 0; res = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin done_cyc = c; res = bus.Result; break; end
      @(negedge clk);
    end
    chk($sformatf("%s_done_cycle", tag), 64'(done_cyc), special ? 64'd1 : 64'd34);
    chk($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), special ? 64'd0 : 64'd33);
    chk($sformatf("%s_result", tag), {32'b0, res}, {32'b0, exp});
    last_exp = exp;
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("%s_done_pulse", tag), {63'b0, bus.Done}, 64'd0);
    end
  endtask

  logic [4:0] ops [6];
  initial begin
    int          done_cyc, done_seen;
    logic [31:0] res, ra, rb;
    logic [4:0]  rop;

    ops[0] = `ALU_MUL; ops[1] = `ALU_MULH; ops[2] = `ALU_MULHSU;
    ops[3] = `ALU_MULHU; ops[4] = `ALU_DIV; ops[5] = `ALU_REM;

    // Reset state
    rst_n = 1'b0; bus.Start = 1'b0; bus.Kill = 1'b0;
    bus.AluOperation = '0; bus.OperandA = '0; bus.OperandB = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   {63'b0, bus.Busy}, 64'd0);
    chk("reset_done",   {63'b0, bus.Done}, 64'd0);
    chk("reset_result", {32'b0, bus.Result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op(`ALU_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3",      1'b0);
    do_op(`ALU_MULH,   32'h8000_0000,  32'h8000_0000, "mulh_min",      1'b0);
    do_op(`ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu_ones",   1'b0);
    do_op(`ALU_DIV,    32'hFFFF_FFF9,  32'd2,         "div_m7_2",      1'b0);
    do_op(`ALU_REM,    32'hFFFF_FFF9,  32'd2,         "rem_m7_2",      1'b0);
    do_op(`ALU_DIV,    32'd100,        32'd7,         "div_100_7",     1'b0);
    do_op(`ALU_REM,    32'd100,        32'd7,         "rem_100_7",     1'b0);
    do_op(`ALU_DIV,    32'd5,          32'd0,         "div_by0",       1'b0);
    do_op(`ALU_REM,    32'd5,          32'd0,         "rem_by0",       1'b0);
    do_op(`ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf",       1'b0);
    do_op(`ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf",       1'b0);

    // Second Start while busy is ignored
    bus.Start = 1'b1; bus.AluOperation = `ALU_MUL; bus.OperandA = 32'd3; bus.OperandB = 32'd4;
    done_cyc = 0; res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.Start = (c == 10);
      if (c == 10) begin bus.OperandA = 32'd9; bus.OperandB = 32'd9; end
      if (bus.Done) begin done_cyc = c; res = bus.Result; break; end
    end
    bus.Start = 1'b0;
    chk("busy_start_done_cycle", 64'(done_cyc), 64'd34);
    chk("busy_start_result", {32'b0, res}, 64'd12);
    last_exp = 32'd12;
    @(negedge clk);

    // Back-to-back: new Start accepted in the DONE cycle
    do_op(`ALU_MUL, 32'h1234, 32'h5678, "b2b_first", 1'b1);
    do_op(`ALU_DIV, 32'd100,  32'd7,    "b2b_second", 1'b0);

    // Unsupported op code with Start is ignored
    bus.Start = 1'b1; bus.AluOperation = 5'd0; bus.OperandA = 32'd1; bus.OperandB = 32'd1;
    @(negedge clk);
    bus.Start = 1'b0;
    chk("badop_busy", {63'b0, bus.Busy}, 64'd0);
    chk("badop_done", {63'b0, bus.Done}, 64'd0);
    chk("badop_result", {32'b0, bus.Result}, {32'b0, last_exp});

    // Kill and Start together: Kill wins
    bus.Start = 1'b1; bus.Kill = 1'b1; bus.AluOperation = `ALU_MUL;
    @(negedge clk);
    bus.Start = 1'b0; bus.Kill = 1'b0;
    chk("killstart_busy", {63'b0, bus.Busy}, 64'd0);
    chk("killstart_done", {63'b0, bus.Done}, 64'd0);

    // Kill in cycle 15 of a DIV
    bus.Start = 1'b1; bus.AluOperation = `ALU_DIV; bus.OperandA = 32'd1000; bus.OperandB = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (14) @(negedge clk);
    chk("kill_busy_before", {63'b0, bus.Busy}, 64'd1);
    bus.Kill = 1'b1;
    @(negedge clk);
    bus.Kill = 1'b0;
    chk("kill_busy_after", {63'b0, bus.Busy}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (bus.Done) done_seen++;
      @(negedge clk);
    end
    chk("kill_no_done", 64'(done_seen), 64'd0);
    chk("kill_result_kept", {32'b0, bus.Result}, {32'b0, last_exp});

    // Random operations, biased towards divide corner cases
    for (int i = 0; i < 24; i++) begin
      rop = ops[$urandom_range(0, 5)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 17);
        3: rb = -$urandom_range(1, 17);
        default: ;
      endcase
      do_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop), 1'b0);
    end

    // Asynchronous reset in cycle 20 of a MUL, after a known non-zero result
    do_op(`ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones", 1'b0);
    bus.Start = 1'b1; bus.AluOperation = `ALU_MUL; bus.OperandA = 32'h12345; bus.OperandB = 32'h777;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (19) @(negedge clk);
    chk("arst_busy_before", {63'b0, bus.Busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {63'b0, bus.Busy}, 64'd0);
    chk("arst_done",   {63'b0, bus.Done}, 64'd0);
    chk("arst_result", {32'b0, bus.Result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(`ALU_MUL, 32'h12345, 32'h777, "after_reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
